// File: rtl/send_seq_pkg.sv
// Shared types and constants for the send_seq message streamer.
// SEND_SEQ_CRLF_EN appends a CR/LF tail to every pass of the message.
package send_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h3000_0004;
    localparam logic [7:0]  CHAR_CR             = 8'h0D;
    localparam logic [7:0]  CHAR_LF             = 8'h0A;

`ifdef SEND_SEQ_CRLF_EN
    localparam int TAIL_LEN = 2;
`else
    localparam int TAIL_LEN = 0;
`endif

    // Width needed to count 0..total characters inclusive.
    function automatic int idx_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/send_seq_rom.sv
// Combinational index -> character lookup over the packed message,
// including the CR/LF tail when SEND_SEQ_CRLF_EN is defined.
module send_seq_rom
    import send_seq_pkg::*;
#(
    parameter int                   MSG_LEN = 10,
    parameter logic [8*MSG_LEN-1:0] MSG     = 80'h32303233323131303133,
    parameter int                   IDX_W   = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       char_o
);

    localparam int TOTAL = MSG_LEN + TAIL_LEN;

    logic [7:0] tbl [TOTAL];

    // First character lives in the most significant byte of MSG.
    generate
        for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_msg
            assign tbl[gi] = MSG[8*(MSG_LEN-1-gi) +: 8];
        end
    endgenerate

`ifdef SEND_SEQ_CRLF_EN
    assign tbl[MSG_LEN]   = CHAR_CR;
    assign tbl[MSG_LEN+1] = CHAR_LF;
`endif

    always_comb begin
        char_o = '0;
        for (int k = 0; k < TOTAL; k++) begin
            if (idx_i == IDX_W'(k)) begin
                char_o = tbl[k];
            end
        end
    end

endmodule

// File: rtl/send_seq.sv
// Streams a constant message one character per observed UART-idle status poll.
// SEND_SEQ_CRLF_EN extends each pass with a CR/LF tail (see send_seq_rom).
module send_seq
    import send_seq_pkg::*;
#(
    parameter int                   MSG_LEN     = 10,
    parameter logic [8*MSG_LEN-1:0] MSG         = 80'h32303233323131303133,
    parameter int                   DATA_W      = 32,
    parameter logic [31:0]          STATUS_ADDR = STATUS_ADDR_DEFAULT,
    parameter int                   BUSY_BIT    = 0,
    parameter int                   REPEAT      = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_i,
    input  logic                                          mem_req_i,
    input  logic                                          mem_we_i,
    input  logic [31:0]                                   mem_addr_i,
    input  logic [31:0]                                   mem_rdata_i,
    output logic [DATA_W-1:0]                             data_o,
    output logic                                          valid_o,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic [$clog2(MSG_LEN+TAIL_LEN+1)-1:0]         idx_o
);

    localparam int TOTAL = MSG_LEN + TAIL_LEN;
    localparam int IDX_W = idx_width(TOTAL);
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEAT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               tx_rdy;
    logic               abort;
    logic [7:0]         rom_char;
    logic               rdata_unused;

    // Only the busy flag of the snooped read data matters.
    assign rdata_unused = ^mem_rdata_i;

    assign tx_rdy = mem_req_i & ~mem_we_i & (mem_addr_i == STATUS_ADDR)
                  & ~mem_rdata_i[BUSY_BIT];

    assign abort = ~start_i & ((state_q == ST_SEND) | (state_q == ST_DRAIN));

    send_seq_rom #(
        .MSG_LEN (MSG_LEN),
        .MSG     (MSG),
        .IDX_W   (IDX_W)
    ) u_rom (
        .idx_i  (idx_q),
        .char_o (rom_char)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (abort) begin
            // Abort wins over a coincident tx_rdy.
            state_d = ST_IDLE;
            idx_d   = '0;
            rep_d   = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_SEND;
                        idx_d   = '0;
                        rep_d   = '0;
                    end
                end
                ST_SEND: begin
                    if (tx_rdy) begin
                        data_d  = DATA_W'(rom_char);
                        valid_d = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // This poll only confirms the last character left the UART.
                    if (tx_rdy) begin
                        if (rep_q < LAST_REP) begin
                            rep_d   = rep_q + 1'b1;
                            idx_d   = '0;
                            state_d = ST_SEND;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!start_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign idx_o   = idx_q;
    assign busy_o  = (state_q == ST_SEND) | (state_q == ST_DRAIN);

endmodule

// File: tb/tb_send_seq.sv
// Scoreboarded bench for send_seq: a default-parameter instance and a
// REPEAT=2 / 3-character instance share one snooped memory bus.
module tb_send_seq;
    import send_seq_pkg::*;

    localparam logic [31:0] STAT  = 32'h3000_0004;
    localparam int          IDXWA = $clog2(10 + TAIL_LEN + 1);
    localparam int          IDXWB = $clog2(3 + TAIL_LEN + 1);

    localparam logic [7:0] MSG_A [10] = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h32,
                                          8'h31, 8'h31, 8'h30, 8'h31, 8'h33};
    localparam logic [7:0] MSG_B [3]  = '{8'h41, 8'h42, 8'h43};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_a, start_b;
    logic              mem_req, mem_we;
    logic [31:0]       mem_addr, mem_rdata;
    logic [31:0]       data_a, data_b;
    logic              valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [IDXWA-1:0]  idx_a;
    logic [IDXWB-1:0]  idx_b;

    int                n_vec = 0;
    int                n_err = 0;
    int                done_cnt_a = 0;
    int                done_cnt_b = 0;
    logic [7:0]        exp_a [$];
    logic [7:0]        exp_b [$];
    logic [7:0]        e_a, e_b;

    always #5 clk = ~clk;

    send_seq u_dut_a (
        .clk         (clk),
        .rst         (rst_n),
        .start_i     (start_a),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .data_o      (data_a),
        .valid_o     (valid_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .idx_o       (idx_a)
    );

    send_seq #(
        .MSG_LEN (3),
        .MSG     (24'h414243),
        .REPEAT  (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst_n),
        .start_i     (start_b),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .data_o      (data_b),
        .valid_o     (valid_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .idx_o       (idx_b)
    );

    // Monitor: every valid strobe must match the next expected character.
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            n_vec++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL dut_a unexpected valid: got data %0h, required no strobe", data_a);
            end else begin
                e_a = exp_a.pop_front();
                if (data_a !== {24'h0, e_a}) begin
                    n_err++;
                    $display("FAIL dut_a char: got %0h required %0h", data_a, e_a);
                end else begin
                    $display("dut_a char %0h", data_a);
                end
            end
        end
        if (rst_n && valid_b) begin
            n_vec++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL dut_b unexpected valid: got data %0h, required no strobe", data_b);
            end else begin
                e_b = exp_b.pop_front();
                if (data_b !== {24'h0, e_b}) begin
                    n_err++;
                    $display("FAIL dut_b char: got %0h required %0h", data_b, e_b);
                end else begin
                    $display("dut_b char %0h", data_b);
                end
            end
        end
        if (rst_n && done_a) done_cnt_a++;
        if (rst_n && done_b) done_cnt_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic bus_cycle(input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] rdata);
        @(negedge clk);
        mem_req   = req;
        mem_we    = we;
        mem_addr  = addr;
        mem_rdata = rdata;
        @(negedge clk);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic poll(input logic busy_bit);
        bus_cycle(1'b1, 1'b0, STAT, {31'h0, busy_bit});
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_rdata = 32'h0;
        gap(3);
        check("reset_data_a",  data_a, 32'h0);
        check("reset_valid_a", 32'(valid_a), 32'h0);
        check("reset_busy_a",  32'(busy_a), 32'h0);
        check("reset_done_a",  32'(done_a), 32'h0);
        check("reset_idx_a",   32'(idx_a), 32'h0);
        check("reset_busy_b",  32'(busy_b), 32'h0);
        rst_n = 1'b1;
        gap(2);

        // Reset in the middle of a transfer.
        start_a = 1'b1;
        gap(2);
        check("start_busy_a", 32'(busy_a), 32'h1);
        check("start_idx_a",  32'(idx_a), 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_a.push_back(MSG_A[k]);
            poll(1'b0);
            gap(4);
        end
        check("mid_idx_a", 32'(idx_a), 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_data_a", data_a, 32'h0);
        check("async_rst_busy_a", 32'(busy_a), 32'h0);
        check("async_rst_idx_a",  32'(idx_a), 32'h0);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap(2);

        // Full message, with non-qualifying bus traffic after two characters.
        start_a = 1'b1;
        gap(2);
        for (int k = 0; k < 10; k++) begin
            exp_a.push_back(MSG_A[k]);
            poll(1'b0);
            gap(4);
            if (k == 1) begin
                poll(1'b1);
                bus_cycle(1'b1, 1'b1, STAT, 32'h0);
                bus_cycle(1'b1, 1'b0, 32'h3000_0008, 32'h0);
                bus_cycle(1'b0, 1'b0, STAT, 32'h0);
                check("noise_idx_frozen", 32'(idx_a), 32'h2);
            end
        end
        check("full_idx_a",  32'(idx_a), 32'd10);
        check("full_busy_a", 32'(busy_a), 32'h1);
        check("full_done_a", 32'(done_a), 32'h0);
        poll(1'b0);
        check("drain_done_a", 32'(done_a), 32'h1);
        check("drain_busy_a", 32'(busy_a), 32'h0);
        gap(1);
        check("done_pulse_a", 32'(done_a), 32'h0);
        poll(1'b0);
        poll(1'b0);
        check("hold_busy_a",    32'(busy_a), 32'h0);
        check("hold_data_a",    data_a, 32'h33);
        check("done_count_a_1", 32'(done_cnt_a), 32'h1);
        start_a = 1'b0;
        gap(2);

        // Abort after three characters, coincident with a tx_rdy.
        start_a = 1'b1;
        gap(2);
        for (int k = 0; k < 3; k++) begin
            exp_a.push_back(MSG_A[k]);
            poll(1'b0);
            gap(2);
        end
        @(negedge clk);
        start_a = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = STAT; mem_rdata = 32'h0;
        @(negedge clk);
        mem_req = 1'b0; mem_addr = 32'h0;
        check("abort_busy_a",  32'(busy_a), 32'h0);
        check("abort_valid_a", 32'(valid_a), 32'h0);
        check("abort_data_a",  data_a, 32'h0);
        check("abort_idx_a",   32'(idx_a), 32'h0);
        poll(1'b0);
        poll(1'b0);
        check("done_count_a_2", 32'(done_cnt_a), 32'h1);

        // Second instance: two passes of a three-character message.
        start_b = 1'b1;
        gap(2);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                exp_b.push_back(MSG_B[k]);
                poll(1'b0);
                gap(2);
            end
            check("pass_idx_b", 32'(idx_b), 32'h3);
            poll(1'b0);
            if (pass == 0) begin
                check("rep_idx_b",  32'(idx_b), 32'h0);
                check("rep_busy_b", 32'(busy_b), 32'h1);
                check("rep_done_b", 32'(done_b), 32'h0);
            end else begin
                check("final_done_b", 32'(done_b), 32'h1);
                check("final_busy_b", 32'(busy_b), 32'h0);
            end
            gap(2);
        end
        poll(1'b0);
        poll(1'b0);
        check("hold_busy_b",  32'(busy_b), 32'h0);
        check("done_count_b", 32'(done_cnt_b), 32'h1);
        start_b = 1'b0;
        gap(3);

        check("pending_a", 32'(exp_a.size()), 32'h0);
        check("pending_b", 32'(exp_b.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
